writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 4, number of buffered writeback entries (power of two, >= 2).
REQ-002 The block SHALL provide port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL provide port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL provide port in_valid  input  1  producer offers a retired result.
REQ-005 The block SHALL provide port in_ready  output  1  queue can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-006 The block SHALL provide port in_rd  input  5  destination register index.
REQ-007 The block SHALL provide port in_data  input  32  result value.
REQ-008 The block SHALL provide port drain_stall  input  1  when 1, no entry leaves the queue.
REQ-009 The block SHALL provide port rf_write_enable  output  1  write strobe to the register-file write port.
REQ-010 The block SHALL provide port rf_addr_rd  output  5  register-file write address.
REQ-011 The block SHALL provide port rf_data_rd  output  32  register-file write data.
REQ-012 The block SHALL provide ports lookup_addr_a/lookup_addr_b  input  5 each  source indices to check against pending writes.
REQ-013 The block SHALL provide ports lookup_hit_a/lookup_hit_b  output  1 each, and lookup_data_a/lookup_data_b  output  32 each  bypass results.
REQ-014 The block SHALL provide port count  output  $clog2(DEPTH)+1  current occupancy; ports empty and full  output  1 each.

Function
REQ-015 in_ready SHALL equal !full, combinationally; no pass-through when full, even if an entry drains in the same cycle.
REQ-016 An accepted transfer with in_rd == 0 SHALL be consumed and discarded (not enqueued, count unchanged).
REQ-017 An accepted transfer with in_rd != 0 SHALL be written at the tail; tail pointer wraps modulo DEPTH.
REQ-018 At each rising edge where the queue is non-empty and drain_stall == 0, the head entry SHALL be popped and registered into rf_addr_rd/rf_data_rd with rf_write_enable = 1 for exactly that following cycle.
REQ-019 At edges with no pop, rf_write_enable SHALL be 0; rf_addr_rd/rf_data_rd SHALL hold their previous values.
REQ-020 Latency: entry accepted at edge E into an empty, unstalled queue SHALL produce rf_write_enable = 1 in the cycle after edge E+1 (register file commits at edge E+2).
REQ-021 Simultaneous accept and pop SHALL leave count unchanged; count SHALL never exceed DEPTH or underflow.
REQ-022 Entries SHALL drain strictly in acceptance order, one per cycle maximum.
REQ-023 Lookup (per port, combinational): the hit search SHALL cover all occupied queue entries plus the output register while rf_write_enable == 1; the youngest matching entry SHALL win; lookup_addr == 0 SHALL never hit.
REQ-024 On a miss, lookup_data SHALL be 0.

Reset
REQ-025 While reset == 0 at a rising edge: head, tail, and count SHALL be set to 0; rf_write_enable, rf_addr_rd, and rf_data_rd SHALL be set to 0; in_valid SHALL be ignored.
REQ-026 Reset mid-operation SHALL discard all pending entries; no rf_write_enable pulse SHALL occur in the cycle following the reset edge.
REQ-027 After reset, the outputs SHALL be empty = 1, full = 0, in_ready = 1, and all lookup hits = 0.

Configuration
REQ-028 With macro WRITEBACK_QUEUE_BYPASS_EN defined, the lookup logic of REQ-023/024 SHALL be compiled in.
REQ-029 Without WRITEBACK_QUEUE_BYPASS_EN, lookup_hit_a/b and lookup_data_a/b SHALL be tied to 0, no compare logic SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Test 1: reset, then accept (rd=5, data=0xDEADBEEF) at edge E -> rf_write_enable=1, rf_addr_rd=5, rf_data_rd=0xDEADBEEF in the cycle after E+1, then 0.
REQ-031 Test 2: drain_stall=1, push 4 entries rd=1..4 -> full=1, in_ready=0, count=4; a 5th in_valid is not accepted; release stall -> writes to rd 1,2,3,4 on 4 consecutive cycles.
REQ-032 Test 3: accept rd=0 data=0x1234 -> count stays 0, no rf_write_enable pulse.
REQ-033 Test 4 (bypass): stall, push rd=7 data=0x11, then rd=7 data=0x22, lookup_addr_a=7 -> hit_a=1, data_a=0x22; lookup_addr_b=8 -> hit_b=0, data_b=0.
REQ-034 Test 5: full queue with simultaneous pop and in_valid -> in_ready=0, no acceptance, count goes 4->3.
REQ-035 Test 6: queue holding 3 entries, reset=0 for one edge -> count=0, empty=1, no rf_write_enable pulse in any later cycle.

Source files
------------

// File: rtl/writeback_queue_if.sv
// Writeback queue bus: producer handshake, drain control, register-file
// write port, bypass lookup ports and occupancy status.
// The slave modport is the queue itself; the master modport is whoever
// drives the producer side and consumes the register-file write port.
interface writeback_queue_if #(
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [4:0]               in_rd;
   logic [31:0]              in_data;
   logic                     drain_stall;
   logic                     rf_write_enable;
   logic [4:0]               rf_addr_rd;
   logic [31:0]              rf_data_rd;
   logic [4:0]               lookup_addr_a;
   logic [4:0]               lookup_addr_b;
   logic                     lookup_hit_a;
   logic                     lookup_hit_b;
   logic [31:0]              lookup_data_a;
   logic [31:0]              lookup_data_b;
   logic [$clog2(DEPTH):0]   count;
   logic                     empty;
   logic                     full;

   modport slave (
      input  in_valid, in_rd, in_data, drain_stall,
      input  lookup_addr_a, lookup_addr_b,
      output in_ready, rf_write_enable, rf_addr_rd, rf_data_rd,
      output lookup_hit_a, lookup_hit_b, lookup_data_a, lookup_data_b,
      output count, empty, full
   );

   modport master (
      output in_valid, in_rd, in_data, drain_stall,
      output lookup_addr_a, lookup_addr_b,
      input  in_ready, rf_write_enable, rf_addr_rd, rf_data_rd,
      input  lookup_hit_a, lookup_hit_b, lookup_data_a, lookup_data_b,
      input  count, empty, full
   );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: buffers retired results (rd, data) in a DEPTH-entry
// circular FIFO and drains at most one entry per cycle into a registered
// register-file write port. Writes to x0 are accepted and dropped.
// Optional bypass lookup (two ports) is built only when the macro
// WRITEBACK_QUEUE_BYPASS_EN is defined; otherwise the lookup outputs are 0.
// The bus interface must be instantiated with the same DEPTH as this module.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   writeback_queue_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Queue storage (data path, not reset; validity is tracked by occ)
   logic [4:0]        rd_mem   [DEPTH];
   logic [31:0]       data_mem [DEPTH];

   // Queue control
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  occ;

   // Output register stage feeding the register-file write port
   logic              vld_p1;
   logic [4:0]        addr_p1;
   logic [31:0]       data_p1;

   logic              q_full;
   logic              q_empty;
   logic              accept;
   logic              push;
   logic              pop;

   assign q_full  = (occ == CNT_W'(DEPTH));
   assign q_empty = (occ == '0);

   // in_ready depends only on the current fill level; a same-cycle drain
   // never opens a slot for the producer.
   assign accept  = bus.in_valid && !q_full;
   assign push    = accept && (bus.in_rd != 5'd0);
   assign pop     = !q_empty && !bus.drain_stall;

   assign bus.in_ready        = !q_full;
   assign bus.full            = q_full;
   assign bus.empty           = q_empty;
   assign bus.count           = occ;
   assign bus.rf_write_enable = vld_p1;
   assign bus.rf_addr_rd      = addr_p1;
   assign bus.rf_data_rd      = data_p1;

   // Pointers, occupancy and the registered write port; reset drops all entries
   always_ff @(posedge clock) begin
      if (!reset) begin
         head    <= '0;
         tail    <= '0;
         occ     <= '0;
         vld_p1  <= 1'b0;
         addr_p1 <= 5'd0;
         data_p1 <= 32'd0;
      end else begin
         if (push) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head    <= head + PTR_W'(1);
            vld_p1  <= 1'b1;
            addr_p1 <= rd_mem[head];
            data_p1 <= data_mem[head];
         end else begin
            vld_p1  <= 1'b0;
         end
         case ({push, pop})
            2'b10:   occ <= occ + CNT_W'(1);
            2'b01:   occ <= occ - CNT_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Entry storage write at the tail; suppressed while reset is asserted
   always_ff @(posedge clock) begin
      if (reset && push) begin
         rd_mem[tail]   <= bus.in_rd;
         data_mem[tail] <= bus.in_data;
      end
   end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
   logic              hit_a;
   logic              hit_b;
   logic [31:0]       byp_a;
   logic [31:0]       byp_b;
   logic [PTR_W-1:0]  idx;

   // Youngest-match search: the output register is oldest, then queue
   // entries from head towards tail, so later matches overwrite earlier ones.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      byp_a = 32'd0;
      byp_b = 32'd0;
      idx   = '0;
      if (vld_p1 && (bus.lookup_addr_a != 5'd0) && (addr_p1 == bus.lookup_addr_a)) begin
         hit_a = 1'b1;
         byp_a = data_p1;
      end
      if (vld_p1 && (bus.lookup_addr_b != 5'd0) && (addr_p1 == bus.lookup_addr_b)) begin
         hit_b = 1'b1;
         byp_b = data_p1;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (CNT_W'(i) < occ) begin
            if ((bus.lookup_addr_a != 5'd0) && (rd_mem[idx] == bus.lookup_addr_a)) begin
               hit_a = 1'b1;
               byp_a = data_mem[idx];
            end
            if ((bus.lookup_addr_b != 5'd0) && (rd_mem[idx] == bus.lookup_addr_b)) begin
               hit_b = 1'b1;
               byp_b = data_mem[idx];
            end
         end
      end
   end

   assign bus.lookup_hit_a  = hit_a;
   assign bus.lookup_hit_b  = hit_b;
   assign bus.lookup_data_a = byp_a;
   assign bus.lookup_data_b = byp_b;
`else
   // Without bypass the lookup addresses are intentionally ignored
   logic unused_lookup;
   assign unused_lookup = ^{bus.lookup_addr_a, bus.lookup_addr_b};

   assign bus.lookup_hit_a  = 1'b0;
   assign bus.lookup_hit_b  = 1'b0;
   assign bus.lookup_data_a = 32'd0;
   assign bus.lookup_data_b = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed vector table covering reset,
// single-entry latency, x0 discard, full/back-pressure, drain order,
// reset with pending entries and bypass lookups, followed by randomized
// traffic checked against a queue-based reference model.
module tb_writeback_queue;

   localparam int DEPTH = 4;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;

   writeback_queue_if #(.DEPTH(DEPTH)) bus();

   writeback_queue #(.DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        rstn;
      logic        vld;
      logic [4:0]  rd;
      logic [31:0] d;
      logic        stall;
      logic [4:0]  la;
      logic [4:0]  lb;
      logic        e_rdy;
      logic [2:0]  e_cnt;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic        e_ha;
      logic [31:0] e_da;
      logic        e_hb;
      logic [31:0] e_db;
   } vec_t;

   vec_t vq[$];

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   // Reference model state
   ent_t        mq[$];
   logic        m_we   = 1'b0;
   logic [4:0]  m_addr = 5'd0;
   logic [31:0] m_data = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rstn, input logic vld, input logic [4:0] rd, input logic [31:0] d,
                      input logic stall, input logic [4:0] la, input logic [4:0] lb,
                      input logic e_rdy, input logic [2:0] e_cnt, input logic e_we,
                      input logic [4:0] e_addr, input logic [31:0] e_data,
                      input logic e_ha, input logic [31:0] e_da, input logic e_hb, input logic [31:0] e_db);
      vec_t v;
      v = '{rstn, vld, rd, d, stall, la, lb, e_rdy, e_cnt, e_we, e_addr, e_data, e_ha, e_da, e_hb, e_db};
      vq.push_back(v);
   endtask

   task automatic drive(input logic rstn, input logic vld, input logic [4:0] rd, input logic [31:0] d,
                        input logic stall, input logic [4:0] la, input logic [4:0] lb);
      reset             = rstn;
      bus.in_valid      = vld;
      bus.in_rd         = rd;
      bus.in_data       = d;
      bus.drain_stall   = stall;
      bus.lookup_addr_a = la;
      bus.lookup_addr_b = lb;
   endtask

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_edge();
      bit   acc;
      bit   popd;
      ent_t e;
      if (!reset) begin
         mq.delete();
         m_we   = 1'b0;
         m_addr = 5'd0;
         m_data = 32'd0;
      end else begin
         acc  = bus.in_valid && (mq.size() < DEPTH);
         popd = (mq.size() > 0) && !bus.drain_stall;
         if (popd) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_addr = e.rd;
            m_data = e.data;
         end else begin
            m_we   = 1'b0;
         end
         if (acc && (bus.in_rd != 5'd0)) begin
            e.rd   = bus.in_rd;
            e.data = bus.in_data;
            mq.push_back(e);
         end
      end
   endtask

   // Latest pending write to register a, or miss
   task automatic model_lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = 32'd0;
      if (BYP && (a != 5'd0)) begin
         if (m_we && (m_addr == a)) begin
            hit = 1'b1;
            d   = m_data;
         end
         foreach (mq[i]) begin
            if (mq[i].rd == a) begin
               hit = 1'b1;
               d   = mq[i].data;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic        ha, hb;
      logic [31:0] da, db;
      model_lookup(bus.lookup_addr_a, ha, da);
      model_lookup(bus.lookup_addr_b, hb, db);
      check({tag, ".count"},  32'(bus.count),      32'(mq.size()));
      check({tag, ".empty"},  32'(bus.empty),      32'(mq.size() == 0));
      check({tag, ".full"},   32'(bus.full),       32'(mq.size() == DEPTH));
      check({tag, ".ready"},  32'(bus.in_ready),   32'(mq.size() != DEPTH));
      check({tag, ".we"},     32'(bus.rf_write_enable), 32'(m_we));
      check({tag, ".addr"},   32'(bus.rf_addr_rd), 32'(m_addr));
      check({tag, ".data"},   bus.rf_data_rd,      m_data);
      check({tag, ".hit_a"},  32'(bus.lookup_hit_a), 32'(ha));
      check({tag, ".data_a"}, bus.lookup_data_a,   da);
      check({tag, ".hit_b"},  32'(bus.lookup_hit_b), 32'(hb));
      check({tag, ".data_b"}, bus.lookup_data_b,   db);
   endtask

   initial begin
      vec_t v;
      string tag;
      logic [31:0] bm;
      bm = {32{BYP}};

      // rstn vld rd  data          stall la  lb | rdy cnt we addr data        ha  da            hb  db
      // reset, in_valid ignored during reset
      add(0, 0, 0,  32'h0,        0, 0,  0,  1, 0, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
      add(0, 1, 3,  32'h33,       0, 3,  0,  1, 0, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
      // single entry latency
      add(1, 1, 5,  32'hDEADBEEF, 0, 5,  0,  1, 1, 0, 0,  32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 5,  0,  1, 0, 1, 5,  32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 5,  0,  1, 0, 0, 5,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      // x0 write discarded
      add(1, 1, 0,  32'h1234,     0, 0,  0,  1, 0, 0, 5,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 0,  0,  1, 0, 0, 5,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      // fill while stalled, 5th offer refused
      add(1, 1, 1,  32'h101,      1, 0,  0,  1, 1, 0, 5,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      add(1, 1, 2,  32'h102,      1, 0,  0,  1, 2, 0, 5,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      add(1, 1, 3,  32'h103,      1, 0,  0,  1, 3, 0, 5,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      add(1, 1, 4,  32'h104,      1, 0,  0,  0, 4, 0, 5,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
      add(1, 1, 9,  32'h109,      1, 4,  9,  0, 4, 0, 5,  32'hDEADBEEF, 1, 32'h104,      0, 32'h0);
      // release stall: in-order drain on consecutive cycles
      add(1, 0, 0,  32'h0,        0, 1,  0,  1, 3, 1, 1,  32'h101,      1, 32'h101,      0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 2,  0,  1, 2, 1, 2,  32'h102,      1, 32'h102,      0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 0,  0,  1, 1, 1, 3,  32'h103,      0, 32'h0,        0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 0,  9,  1, 0, 1, 4,  32'h104,      0, 32'h0,        0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 4,  0,  1, 0, 0, 4,  32'h104,      0, 32'h0,        0, 32'h0);
      // full queue with simultaneous pop and offer
      add(1, 1, 10, 32'h20A,      1, 0,  0,  1, 1, 0, 4,  32'h104,      0, 32'h0,        0, 32'h0);
      add(1, 1, 11, 32'h20B,      1, 0,  0,  1, 2, 0, 4,  32'h104,      0, 32'h0,        0, 32'h0);
      add(1, 1, 12, 32'h20C,      1, 0,  0,  1, 3, 0, 4,  32'h104,      0, 32'h0,        0, 32'h0);
      add(1, 1, 13, 32'h20D,      1, 0,  0,  0, 4, 0, 4,  32'h104,      0, 32'h0,        0, 32'h0);
      add(1, 1, 14, 32'h20E,      0, 14, 10, 1, 3, 1, 10, 32'h20A,      0, 32'h0,        1, 32'h20A);
      add(1, 0, 0,  32'h0,        1, 0,  0,  1, 3, 0, 10, 32'h20A,      0, 32'h0,        0, 32'h0);
      // reset with 3 pending entries, no later pulse
      add(0, 0, 0,  32'h0,        0, 0,  0,  1, 0, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 11, 12, 1, 0, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 13, 0,  1, 0, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
      // bypass: youngest match wins
      add(1, 1, 7,  32'h11,       1, 7,  0,  1, 1, 0, 0,  32'h0,        1, 32'h11,       0, 32'h0);
      add(1, 1, 7,  32'h22,       1, 7,  8,  1, 2, 0, 0,  32'h0,        1, 32'h22,       0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 7,  0,  1, 1, 1, 7,  32'h11,       1, 32'h22,       0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 7,  0,  1, 0, 1, 7,  32'h22,       1, 32'h22,       0, 32'h0);
      add(1, 0, 0,  32'h0,        0, 7,  0,  1, 0, 0, 7,  32'h22,       0, 32'h0,        0, 32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         drive(v.rstn, v.vld, v.rd, v.d, v.stall, v.la, v.lb);
         @(posedge clock);
         #1;
         tag = $sformatf("vec%0d", i);
         check({tag, ".count"},  32'(bus.count),           32'(v.e_cnt));
         check({tag, ".empty"},  32'(bus.empty),           32'(v.e_cnt == 3'd0));
         check({tag, ".full"},   32'(bus.full),            32'(v.e_cnt == 3'(DEPTH)));
         check({tag, ".ready"},  32'(bus.in_ready),        32'(v.e_rdy));
         check({tag, ".we"},     32'(bus.rf_write_enable), 32'(v.e_we));
         check({tag, ".addr"},   32'(bus.rf_addr_rd),      32'(v.e_addr));
         check({tag, ".data"},   bus.rf_data_rd,           v.e_data);
         check({tag, ".hit_a"},  32'(bus.lookup_hit_a),    32'(v.e_ha & BYP));
         check({tag, ".data_a"}, bus.lookup_data_a,        v.e_da & bm);
         check({tag, ".hit_b"},  32'(bus.lookup_hit_b),    32'(v.e_hb & BYP));
         check({tag, ".data_b"}, bus.lookup_data_b,        v.e_db & bm);
      end

      // Randomized traffic against the reference model, starting from reset
      drive(0, 0, 0, 32'h0, 0, 0, 0);
      model_edge();
      @(posedge clock);
      #1;
      check_model("rnd_reset");

      for (int c = 0; c < 1500; c++) begin
         drive(($urandom_range(0, 49) != 0),
               ($urandom_range(0, 2) != 0),
               5'($urandom_range(0, 7)),
               $urandom(),
               ($urandom_range(0, 2) == 0),
               5'($urandom_range(0, 8)),
               5'($urandom_range(0, 8)));
         check("rnd.ready_pre", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
         model_edge();
         @(posedge clock);
         #1;
         check_model($sformatf("rnd%0d", c));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
